array_4_ctrl: RTL and testbench

Sequencer for the 16-bit binary-parallel HEIGHT×WIDTH systolic array. One `start` runs one complete tile: clear, weight preload, skewed input streaming, and output drain. It drives the per-row `en_i`/`clr_i`, per-column `en_w`/`clr_w`/`en_o`/`clr_o` enables of the array, plus buffer read strobes and output-valid flags. It sits between the tile scheduler (start/done handshake) and the array plus its ifm/weight/ofm buffers.

---
 rtl/array_4_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_array_4_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_4_ctrl.sv
// Sequences one systolic-array tile (clear, weight preload, skewed streaming, drain).
// Latency: start to done is HEIGHT + k_len + WIDTH + OLAT + 1 edges; all outputs registered.
// Backpressure: none; start is only accepted in IDLE, and abort returns to IDLE on the next edge.
module array_4_ctrl #(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int CNTW   = 16,
  parameter int OLAT   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNTW-1:0]   k_len,
  output logic              busy,
  output logic              done,
  output logic [HEIGHT-1:0] en_i,
  output logic [HEIGHT-1:0] clr_i,
  output logic [WIDTH-1:0]  en_w,
  output logic [WIDTH-1:0]  clr_w,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o,
  output logic              wght_rd,
  output logic [HEIGHT-1:0] ifm_rd,
  output logic [WIDTH-1:0]  ofm_vld
);

  localparam int WCW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  // One extra bit so k_len + WIDTH - 1 + OLAT never wraps for the largest k_len.
  localparam int TW  = CNTW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WLOAD,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          state_q, state_nx;
  logic [WCW-1:0]  wcnt_q, wcnt_nx;
  logic [TW-1:0]   t_q, t_nx;
  logic [CNTW-1:0] klen_q, klen_nx;
  logic [TW-1:0]   last_t;

  logic              busy_nx, done_nx, wght_rd_nx;
  logic [HEIGHT-1:0] en_i_nx, clr_i_nx, ifm_rd_nx;
  logic [WIDTH-1:0]  en_w_nx, clr_w_nx, en_o_nx, clr_o_nx, ofm_vld_nx;
  logic [31:0]       t32, k32;

  // Final stream index: k_len + WIDTH - 1 + OLAT cycles, counted from 0.
  assign last_t = TW'(klen_q) + TW'(WIDTH - 2 + OLAT);

  // Next-state and counter sequencing; abort overrides everything outside IDLE.
  always_comb begin
    state_nx = state_q;
    wcnt_nx  = wcnt_q;
    t_nx     = t_q;
    klen_nx  = klen_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          klen_nx  = k_len;
          state_nx = (k_len == '0) ? S_DONE : S_CLR;
        end
      end
      S_CLR: begin
        wcnt_nx  = '0;
        state_nx = S_WLOAD;
      end
      S_WLOAD: begin
        if (wcnt_q == WCW'(HEIGHT - 1)) begin
          t_nx     = '0;
          state_nx = S_STREAM;
        end else begin
          wcnt_nx = wcnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (t_q == last_t) begin
          state_nx = S_DONE;
        end else begin
          t_nx = t_q + 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (abort && state_q != S_IDLE) begin
      state_nx = S_IDLE;
    end
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    wght_rd_nx = 1'b0;
    en_i_nx    = '0;
    clr_i_nx   = '0;
    ifm_rd_nx  = '0;
    en_w_nx    = '0;
    clr_w_nx   = '0;
    en_o_nx    = '0;
    clr_o_nx   = '0;
    ofm_vld_nx = '0;
    t32        = 32'(t_nx);
    k32        = 32'(klen_nx);
    case (state_nx)
      S_CLR: begin
        busy_nx  = 1'b1;
        clr_i_nx = '1;
        clr_w_nx = '1;
        clr_o_nx = '1;
      end
      S_WLOAD: begin
        busy_nx    = 1'b1;
        en_w_nx    = '1;
        wght_rd_nx = 1'b1;
      end
      S_STREAM: begin
        busy_nx = 1'b1;
        // Row h sees its k_len vectors delayed by h cycles (input skew).
        for (int h = 0; h < HEIGHT; h++) begin
          en_i_nx[h]   = (t32 >= 32'(h)) && (t32 < 32'(h) + k32);
          ifm_rd_nx[h] = en_i_nx[h];
        end
        // Column w accumulates with a w-cycle skew; results emerge OLAT later.
        for (int w = 0; w < WIDTH; w++) begin
          en_o_nx[w]    = (t32 >= 32'(w)) && (t32 < 32'(w) + k32);
          ofm_vld_nx[w] = (t32 >= 32'(w + OLAT)) && (t32 < 32'(w + OLAT) + k32);
        end
      end
      S_DONE: begin
        done_nx = 1'b1;
      end
      default: begin
        busy_nx = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      t_q     <= '0;
      klen_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wght_rd <= 1'b0;
      en_i    <= '0;
      clr_i   <= '0;
      ifm_rd  <= '0;
      en_w    <= '0;
      clr_w   <= '0;
      en_o    <= '0;
      clr_o   <= '0;
      ofm_vld <= '0;
    end else begin
      state_q <= state_nx;
      wcnt_q  <= wcnt_nx;
      t_q     <= t_nx;
      klen_q  <= klen_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      wght_rd <= wght_rd_nx;
      en_i    <= en_i_nx;
      clr_i   <= clr_i_nx;
      ifm_rd  <= ifm_rd_nx;
      en_w    <= en_w_nx;
      clr_w   <= clr_w_nx;
      en_o    <= en_o_nx;
      clr_o   <= clr_o_nx;
      ofm_vld <= ofm_vld_nx;
    end
  end

endmodule

// File: tb/tb_array_4_ctrl.sv
// Testbench for array_4_ctrl: hand table for the nominal tile, phase-based reference model
// for directed and random tiles, plus reset, abort and maximum-length corner cases.
// Cycle c is the interval just after edge c-1, where edge 0 samples start.
module tb_array_4_ctrl;

  localparam int H  = 4;
  localparam int W  = 4;
  localparam int CW = 16;
  localparam int OL = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] k_len = '0;
  logic          busy, done, wght_rd;
  logic [H-1:0]  en_i, clr_i, ifm_rd;
  logic [W-1:0]  en_w, clr_w, en_o, clr_o, ofm_vld;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         wght_rd;
    logic [H-1:0] en_i;
    logic [H-1:0] clr_i;
    logic [H-1:0] ifm_rd;
    logic [W-1:0] en_w;
    logic [W-1:0] clr_w;
    logic [W-1:0] en_o;
    logic [W-1:0] clr_o;
    logic [W-1:0] ofm_vld;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t exp;
  } vec_t;

  outs_t cur;
  outs_t obs [0:31];
  int    n_checks = 0;
  int    n_fail   = 0;

  array_4_ctrl #(.HEIGHT(H), .WIDTH(W), .CNTW(CW), .OLAT(OL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done), .en_i(en_i), .clr_i(clr_i), .en_w(en_w),
    .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o), .wght_rd(wght_rd),
    .ifm_rd(ifm_rd), .ofm_vld(ofm_vld)
  );

  always #5 clk = ~clk;

  assign cur = {busy, done, wght_rd, en_i, clr_i, ifm_rd, en_w, clr_w, en_o, clr_o, ofm_vld};

  // Expected outputs in cycle c of a tile of length k, aborted at edge ab (-1 = never).
  function automatic outs_t model(input int c, input int k, input int ab);
    outs_t o;
    int    len;
    int    t;
    o   = '0;
    len = k + W - 1 + OL;
    if (ab >= 0 && c > ab) return o;
    if (k == 0) begin
      if (c == 1) o.done = 1'b1;
      return o;
    end
    if (c == 1) begin
      o.busy = 1'b1; o.clr_i = '1; o.clr_w = '1; o.clr_o = '1;
    end else if (c >= 2 && c <= H + 1) begin
      o.busy = 1'b1; o.en_w = '1; o.wght_rd = 1'b1;
    end else if (c >= H + 2 && c < H + 2 + len) begin
      t = c - (H + 2);
      o.busy = 1'b1;
      for (int h = 0; h < H; h++) begin
        o.en_i[h]   = (t >= h && t < h + k);
        o.ifm_rd[h] = (t >= h && t < h + k);
      end
      for (int w = 0; w < W; w++) begin
        o.en_o[w]    = (t >= w && t < w + k);
        o.ofm_vld[w] = (t >= w + OL && t < w + OL + k);
      end
    end else if (c == H + 2 + len) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic outs_t mk(input logic b, input logic d, input logic wr, input logic [3:0] clr,
                               input logic [3:0] ew, input logic [3:0] ei, input logic [3:0] eo,
                               input logic [3:0] ov);
    outs_t o;
    o = '0;
    o.busy = b; o.done = d; o.wght_rd = wr;
    o.clr_i = clr; o.clr_w = clr; o.clr_o = clr;
    o.en_w = ew; o.en_i = ei; o.ifm_rd = ei; o.en_o = eo; o.ofm_vld = ov;
    return o;
  endfunction

  task automatic check(input string nm, input int c, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Runs one tile from edge 0; xs1/xs2 are edges of extra (ignored) start pulses.
  task automatic run_tile(input string nm, input int k, input int ab,
                          input int xs1, input int xs2, input bit rec);
    int len;
    int n;
    len = k + W - 1 + OL;
    if (ab >= 0)     n = ab + 1;
    else if (k == 0) n = 2;
    else             n = H + 3 + len;
    for (int e = 0; e < n; e++) begin
      start = (e == 0) || (e == xs1) || (e == xs2);
      k_len = (e == 0) ? 16'(k) : 16'($urandom);
      abort = (e == ab);
      @(posedge clk); #1;
      check(nm, e + 1, cur, model(e + 1, k, ab));
      if (rec && e + 1 < 32) obs[e + 1] = cur;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1,  mk(1, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0)};
    tbl[1]  = '{2,  mk(1, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0)};
    tbl[2]  = '{5,  mk(1, 0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0)};
    tbl[3]  = '{6,  mk(1, 0, 0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0)};
    tbl[4]  = '{8,  mk(1, 0, 0, 4'h0, 4'h0, 4'h7, 4'h7, 4'h0)};
    tbl[5]  = '{9,  mk(1, 0, 0, 4'h0, 4'h0, 4'hE, 4'hE, 4'h0)};
    tbl[6]  = '{11, mk(1, 0, 0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h1)};
    tbl[7]  = '{14, mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hE)};
    tbl[8]  = '{16, mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8)};
    tbl[9]  = '{17, mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0)};
    tbl[10] = '{18, mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0)};

    // Reset and quiet idle.
    repeat (3) @(posedge clk);
    #1 check("reset", 0, cur, '0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle", i, cur, '0);
    end

    // Nominal tile checked per cycle by the model and at key cycles by the table.
    run_tile("nominal", 3, -1, -1, -1, 1'b1);
    for (int i = 0; i < 11; i++) check("table", tbl[i].cyc, obs[tbl[i].cyc], tbl[i].exp);

    run_tile("zero_len", 0, -1, -1, -1, 1'b0);
    run_tile("abort", 3, 8, -1, -1, 1'b0);
    run_tile("after_abort", 3, -1, -1, -1, 1'b0);
    run_tile("ignored_start", 3, -1, 3, 10, 1'b0);

    // Abort together with start in IDLE: nothing starts.
    start = 1'b1; abort = 1'b1; k_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_start_idle", i, cur, '0);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a tile.
    start = 1'b1; k_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_rst", 0, cur, '0);
    @(posedge clk); #1;
    check("async_rst_hold", 1, cur, '0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("after_rst", i, cur, '0);
    end

    // Randomized tiles with optional aborts and stray start pulses.
    for (int r = 0; r < 30; r++) begin
      int k, ab, lastb, xs1, xs2;
      k  = $urandom_range(0, 9);
      ab = -1;
      if (k > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, H + 2 + k + W - 1 + OL);
      lastb = (ab >= 0) ? ab : ((k == 0) ? 1 : H + 2 + k + W - 1 + OL);
      xs1 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lastb) : -1;
      xs2 = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lastb) : -1;
      run_tile("random", k, ab, xs1, xs2, 1'b0);
    end

    // Maximum k_len: stream counter must not wrap.
    begin
      int len, n, ei0, ov3, dn, dcyc, bz;
      len = 65535 + W - 1 + OL;
      n   = H + 3 + len;
      ei0 = 0; ov3 = 0; dn = 0; dcyc = -1; bz = 0;
      for (int e = 0; e < n; e++) begin
        start = (e == 0);
        k_len = 16'hFFFF;
        @(posedge clk); #1;
        if (en_i[0]) ei0++;
        if (ofm_vld[3]) ov3++;
        if (busy) bz++;
        if (done) begin dn++; dcyc = e + 1; end
      end
      start = 1'b0;
      check_int("max_en_i0_cycles", ei0, 65535);
      check_int("max_ofm_vld3_cycles", ov3, 65535);
      check_int("max_busy_cycles", bz, 1 + H + len);
      check_int("max_done_count", dn, 1);
      check_int("max_done_cycle", dcyc, H + 2 + len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
